// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and the occupancy-counter width helper.
package fifo_pkg;

  localparam int DEF_N_BITS  = 32;
  localparam int DEF_N_CELLS = 16;

  // Width that holds 0..n inclusive, so a full FIFO can report its depth.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/token_ring.sv
// One-hot rotate register: the token moves from cell i to i+1 (N-1 wraps to 0) on each advance.
module token_ring #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_adv,
  output logic [N-1:0] o_ring,
  output logic         o_bad
);

  logic [N-1:0] r_ring;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ring <= N'(1);
    end else if (i_adv) begin
      r_ring <= {r_ring[N-2:0], r_ring[N-1]};
    end
  end

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  logic [N-1:0] w_low_cleared;
  assign w_low_cleared = r_ring & (r_ring - N'(1));
  assign o_bad         = (r_ring == '0) || (w_low_cleared != '0);
  assign o_ring        = r_ring;

endmodule

// File: rtl/token_ring_fifo.sv
// Synchronous FIFO addressed by one-hot put/get token rings; registered read data, sticky errors.
module token_ring_fifo
  import fifo_pkg::*;
#(
  parameter int N_BITS   = DEF_N_BITS,
  parameter int N_CELLS  = DEF_N_CELLS,
  parameter int AF_LEVEL = N_CELLS - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_put,
  input  logic [N_BITS-1:0]           data_put,
  input  logic                        req_get,
  input  logic                        clr_err,
  output logic [N_BITS-1:0]           data_get,
  output logic                        valid_get,
  output logic                        full_out,
  output logic                        empty_out,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [cnt_w(N_CELLS)-1:0]   count,
  output logic                        ovf_err,
  output logic                        udf_err,
  output logic                        tok_err
);

  localparam int CW = cnt_w(N_CELLS);
  localparam logic [CW-1:0] FULL_CNT = CW'(N_CELLS);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [N_BITS-1:0]  r_mem [N_CELLS];
  logic [CW-1:0]      r_count;
  logic [N_BITS-1:0]  r_data;
  logic               r_valid;
  logic               r_ovf;
  logic               r_udf;
  logic               r_tok;

  logic [N_CELLS-1:0] w_put_tok;
  logic [N_CELLS-1:0] w_get_tok;
  logic               w_put_bad;
  logic               w_get_bad;
  logic               w_full;
  logic               w_empty;
  logic               w_put_acc;
  logic               w_get_acc;
  logic [N_BITS-1:0]  w_rd;

  // Flags come from registered count only, so requests never reach them combinationally.
  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_put_acc = req_put & ~w_full;
  assign w_get_acc = req_get & ~w_empty;

  token_ring #(.N(N_CELLS)) u_put_ring (
    .clk    (clk),
    .reset  (reset),
    .i_adv  (w_put_acc),
    .o_ring (w_put_tok),
    .o_bad  (w_put_bad)
  );

  token_ring #(.N(N_CELLS)) u_get_ring (
    .clk    (clk),
    .reset  (reset),
    .i_adv  (w_get_acc),
    .o_ring (w_get_tok),
    .o_bad  (w_get_bad)
  );

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CELLS; i++) begin
      if (w_put_acc && w_put_tok[i]) begin
        r_mem[i] <= data_put;
      end
    end
  end

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      if (w_get_tok[i]) begin
        w_rd = w_rd | r_mem[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_get_acc;
      if (w_get_acc) begin
        r_data <= w_rd;
      end
      if (w_put_acc && !w_get_acc) begin
        r_count <= r_count + CW'(1);
      end else if (w_get_acc && !w_put_acc) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // A new error wins over a coincident clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
      r_tok <= 1'b0;
    end else begin
      r_ovf <= (req_put & w_full)       | (r_ovf & ~clr_err);
      r_udf <= (req_get & w_empty)      | (r_udf & ~clr_err);
      r_tok <= (w_put_bad | w_get_bad)  | (r_tok & ~clr_err);
    end
  end

  assign data_get     = r_data;
  assign valid_get    = r_valid;
  assign full_out     = w_full;
  assign empty_out    = w_empty;
  assign almost_full  = (r_count >= AF_CNT);
  assign almost_empty = (r_count <= AE_CNT);
  assign count        = r_count;
  assign ovf_err      = r_ovf;
  assign udf_err      = r_udf;
  assign tok_err      = r_tok;

endmodule

// File: tb/tb_token_ring_fifo.sv
// Directed bench for token_ring_fifo at N_CELLS=16, N_BITS=32.
module tb_token_ring_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_put;
  logic [31:0] data_put;
  logic        req_get;
  logic        clr_err;
  logic [31:0] data_get;
  logic        valid_get;
  logic        full_out;
  logic        empty_out;
  logic        almost_full;
  logic        almost_empty;
  logic [4:0]  count;
  logic        ovf_err;
  logic        udf_err;
  logic        tok_err;

  int n_vec = 0;
  int n_err = 0;

  token_ring_fifo #(.N_BITS(32), .N_CELLS(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_put      (req_put),
    .data_put     (data_put),
    .req_get      (req_get),
    .clr_err      (clr_err),
    .data_get     (data_get),
    .valid_get    (valid_get),
    .full_out     (full_out),
    .empty_out    (empty_out),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .ovf_err      (ovf_err),
    .udf_err      (udf_err),
    .tok_err      (tok_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] d);
    req_put  = 1'b1;
    data_put = d;
    tick();
    req_put  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_put = 1'b0; req_get = 1'b0; clr_err = 1'b0; data_put = '0;
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty_out, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full_out, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_valid", valid_get, 0);
    chk("rst_data", data_get, 0);
    chk("rst_errs", {ovf_err, udf_err, tok_err}, 0);
    reset = 1'b0;
    tick();

    // Fill with 0..15.
    for (int i = 0; i < 16; i++) begin
      put(i);
      chk("fill_count", count, i + 1);
      chk("fill_afull", almost_full, (i + 1) >= 14);
      chk("fill_aempty", almost_empty, (i + 1) <= 2);
    end
    chk("fill_full", full_out, 1);
    put(32'hDEAD);
    chk("ovf_set", ovf_err, 1);
    chk("ovf_count", count, 16);

    // Drain and expect 0..15.
    for (int i = 0; i < 16; i++) begin
      req_get = 1'b1;
      tick();
      chk("drain_valid", valid_get, 1);
      chk("drain_data", data_get, i);
      chk("drain_count", count, 15 - i);
    end
    req_get = 1'b0;
    tick();
    chk("drain_idle_valid", valid_get, 0);
    chk("drain_hold_data", data_get, 15);
    chk("drain_empty", empty_out, 1);
    req_get = 1'b1;
    tick();
    req_get = 1'b0;
    chk("udf_set", udf_err, 1);
    chk("udf_valid", valid_get, 0);

    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_ovf", ovf_err, 0);
    chk("clr_udf", udf_err, 0);

    // Steady state at count 5 across several token wraps.
    for (int i = 0; i < 5; i++) put(100 + i);
    chk("steady_pre_count", count, 5);
    for (int k = 0; k < 40; k++) begin
      req_put  = 1'b1;
      req_get  = 1'b1;
      data_put = 105 + k;
      tick();
      chk("steady_count", count, 5);
      chk("steady_valid", valid_get, 1);
      chk("steady_data", data_get, 100 + k);
    end
    req_put = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_get = 1'b1;
      tick();
      chk("steady_tail", data_get, 140 + i);
    end
    req_get = 1'b0;
    tick();
    chk("steady_empty", empty_out, 1);

    // Both requests while empty: only the put is taken.
    req_put = 1'b1; req_get = 1'b1; data_put = 32'h77;
    tick();
    req_put = 1'b0; req_get = 1'b0;
    chk("both_empty_count", count, 1);
    chk("both_empty_valid", valid_get, 0);
    chk("both_empty_udf", udf_err, 1);
    for (int i = 0; i < 15; i++) put(200 + i);
    chk("both_prefull", full_out, 1);
    req_put = 1'b1; req_get = 1'b1; data_put = 32'h99;
    tick();
    req_put = 1'b0; req_get = 1'b0;
    chk("both_full_count", count, 15);
    chk("both_full_valid", valid_get, 1);
    chk("both_full_data", data_get, 32'h77);
    chk("both_full_ovf", ovf_err, 1);

    // Async reset mid-stream after 7 puts.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) put(32'h300 + i);
    chk("pre_rst_count", count, 7);
    req_put = 1'b1; data_put = 32'h33;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty_out, 1);
    chk("mid_rst_errs", {ovf_err, udf_err, tok_err}, 0);
    tick();
    reset = 1'b0; req_put = 1'b0;
    tick();
    chk("post_rst_count", count, 0);
    put(32'hA5);
    req_get = 1'b1;
    tick();
    req_get = 1'b0;
    chk("post_rst_valid", valid_get, 1);
    chk("post_rst_data", data_get, 32'hA5);

    // Overflow coinciding with clear keeps the flag set.
    for (int i = 0; i < 16; i++) put(i);
    req_put = 1'b1;
    tick();
    chk("ovf2_set", ovf_err, 1);
    clr_err = 1'b1;
    tick();
    chk("ovf_clr_collide", ovf_err, 1);
    req_put = 1'b0;
    tick();
    clr_err = 1'b0;
    chk("ovf_clr_final", ovf_err, 0);
    chk("tok_ok", tok_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
